boolean_min_sweeper: RTL and testbench
======================================

Name: boolean_min_sweeper

Overview:
Self-test sequencer for the minimized two-function logic block (f1 over a,b,c,d; f2 over w,x,y,z).
- On a start pulse, drives all 16 input combinations onto both functions in parallel.
- Samples the returned f1/f2 and compares each against golden truth tables.
- Reports mismatch count, first failing index and pass/fail.
- Sits beside the combinational block as its on-chip exhaustive checker.

Parameters:
F1_TT, 16'h35A5, golden f1 truth table; bit i = f1 at {a,b,c,d}=i (a is MSB); minterms 0,2,5,7,8,10,12,13
F2_TT, 16'hEEE2, golden f2 truth table; bit i = f2 at {w,x,y,z}=i (w is MSB); minterms 1,5,6,7,9,10,11,13,14,15
SETTLE, 1, cycles a vector is held before sampling (legal range 1..15)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin a sweep; accepted only in IDLE or DONE
f1  input  1  f1 result from the minimized block
f2  input  1  f2 result from the minimized block
a,b,c,d  output  1 each  registered f1 stimulus = idx[3:0], a is MSB
w,x,y,z  output  1 each  registered f2 stimulus = idx[3:0], w is MSB
busy  output  1  high in DRIVE/SAMPLE
done  output  1  high while in DONE
pass  output  1  valid when done; 1 iff err_cnt==0
err_cnt  output  5  number of vectors where f1 or f2 mismatched (0..16)
first_err_idx  output  4  index of the first mismatching vector
first_err_valid  output  1  at least one mismatch recorded this sweep

Behaviour:
Reset (rst=1 at clock edge):
- State goes to IDLE.
- All outputs go to 0: idx, settle counter, stimulus, busy, done, pass, err_cnt, first_err_idx, first_err_valid.
- Reset overrides every state, including mid-sweep. Partial results are discarded.

States:
- IDLE: waits for start. On start, clear err_cnt, first_err_* and pass; set idx=0 and settle counter=0; go to DRIVE.
- DRIVE: stimulus outputs equal idx. Counter increments each cycle. When counter==SETTLE-1, go to SAMPLE.
- SAMPLE: compare f1 with F1_TT[idx] and f2 with F2_TT[idx].
  - On mismatch (either function), err_cnt+1 (saturating at 16, unreachable by construction).
  - On the first mismatch of the sweep, also set first_err_idx=idx and first_err_valid=1.
  - If idx==15, go to DONE with pass=(final err_cnt==0), counting this vector. Otherwise idx+1, counter=0, go to DRIVE.
- DONE: done=1 and results are held. Stimulus holds 4'hF. start restarts the sweep exactly as from IDLE.

Timing:
- Each vector occupies SETTLE+1 cycles, so a sweep takes 16*(SETTLE+1) cycles.
- The first DRIVE cycle follows the start cycle. done rises 16*(SETTLE+1) cycles after the start edge.
- Stimulus outputs change only on the DRIVE entry edge and are stable through SAMPLE.
- busy and done are never high together.

Boundary conditions:
- start while busy: ignored, no restart.
- start and rst together: rst wins.
- idx wraps only via a new start, never from 15 to 0 inside a sweep.
- f1/f2 are sampled only in SAMPLE; their values in other states are don't-care.

Optional Feature:
Macro BOOLEAN_MIN_SWEEPER_ERR_MASK_EN.
- Defined: adds outputs f1_err_mask[15:0] and f2_err_mask[15:0].
  - Bit i is set in SAMPLE when the respective function mismatched at idx=i.
  - Both masks clear on start and on rst, and are held in DONE.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Correct reference model of the minimized block on f1/f2, SETTLE=1, pulse start -> busy for 32 cycles, done at cycle 32, err_cnt=0, pass=1, first_err_valid=0.
- f1 tied to 0, f2 correct -> err_cnt=8, first_err_idx=0, first_err_valid=1, pass=0; with macro, f1_err_mask=16'h35A5 and f2_err_mask=0.
- f2 inverted only at idx 9 -> err_cnt=1, first_err_idx=9, pass=0; with macro, f2_err_mask=16'h0200.
- SETTLE=3, correct model -> stimulus steps every 4 cycles, done 64 cycles after start, pass=1.
- start pulsed again at cycle 10 of a sweep -> ignored, done still at cycle 32 with unchanged results; a new start in DONE reruns and clears the previous err_cnt.
- rst asserted at cycle 15 of a sweep -> next cycle IDLE, all outputs 0; a following start performs a full clean sweep.

Source files
------------

// File: rtl/boolean_min_sweeper.sv
// Exhaustive on-chip checker for the minimized f1/f2 logic block: sweeps all 16
// input codes, compares against golden truth tables. Optional: BOOLEAN_MIN_SWEEPER_ERR_MASK_EN.
module boolean_min_sweeper #(
  parameter logic [15:0] F1_TT  = 16'h35A5,
  parameter logic [15:0] F2_TT  = 16'hEEE2,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f1,
  input  logic        f2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_err_idx,
  output logic        first_err_valid
`ifdef BOOLEAN_MIN_SWEEPER_ERR_MASK_EN
  ,
  output logic [15:0] f1_err_mask,
  output logic [15:0] f2_err_mask
`endif
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // DRIVE  | stimulus = idx, settling for SETTLE cycles
  // SAMPLE | compare f1/f2 against golden tables, advance idx
  // DONE   | results held, start reruns the sweep
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] cnt;
  logic [3:0] stim;
  logic       mis1, mis2, mis;
  logic [4:0] err_inc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mis1      = (f1 != F1_TT[idx]);
    mis2      = (f2 != F2_TT[idx]);
    mis       = mis1 | mis2;
    err_inc   = (err_cnt == 5'd16) ? 5'd16 : err_cnt + 5'd1;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy = 1'b1;
        state_nxt = (idx == 4'hF) ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_DRIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= 4'd0;
      cnt             <= 4'd0;
      stim            <= 4'd0;
      pass            <= 1'b0;
      err_cnt         <= 5'd0;
      first_err_idx   <= 4'd0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx             <= 4'd0;
            cnt             <= 4'd0;
            stim            <= 4'd0;
            pass            <= 1'b0;
            err_cnt         <= 5'd0;
            first_err_idx   <= 4'd0;
            first_err_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          cnt <= cnt + 4'd1;
        end
        S_SAMPLE: begin
          if (mis) begin
            err_cnt <= err_inc;
            if (!first_err_valid) begin
              first_err_idx   <= idx;
              first_err_valid <= 1'b1;
            end
          end
          // pass must account for the vector being sampled right now
          if (idx == 4'hF) begin
            pass <= (err_cnt == 5'd0) && !mis;
          end else begin
            idx  <= idx + 4'd1;
            cnt  <= 4'd0;
            stim <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BOOLEAN_MIN_SWEEPER_ERR_MASK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      f1_err_mask <= 16'd0;
      f2_err_mask <= 16'd0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      f1_err_mask <= 16'd0;
      f2_err_mask <= 16'd0;
    end else if (state == S_SAMPLE) begin
      if (mis1) f1_err_mask[idx] <= 1'b1;
      if (mis2) f2_err_mask[idx] <= 1'b1;
    end
  end
`endif

  assign {a, b, c, d} = stim;
  assign {w, x, y, z} = stim;

endmodule

// File: tb/tb_boolean_min_sweeper.sv
// Bench for boolean_min_sweeper: table vectors, random fault masks against a
// truth-table reference, and hand sequences for restart/reset/SETTLE corners.
module tb_boolean_min_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start3;
  logic tie0;
  logic [15:0] flip1, flip2;

  logic f1_1, f2_1, a1, b1, c1, d1, w1, x1, y1, z1, busy1, done1, pass1, fv1;
  logic [4:0] err1;
  logic [3:0] fidx1;
  logic [15:0] m1_1, m2_1;

  logic f1_3, f2_3, a3, b3, c3, d3, w3, x3, y3, z3, busy3, done3, pass3, fv3;
  logic [4:0] err3;
  logic [3:0] fidx3;
  logic [15:0] m1_3, m2_3;

  int errors = 0;
  int checks = 0;
  logic [15:0] g1, g2;

  // Minimized sum-of-products forms of the two functions
  function automatic logic f1_model(input logic [3:0] v);
    return (!v[2] && !v[0]) || (!v[3] && v[2] && v[0]) || (v[3] && v[2] && !v[1]);
  endfunction
  function automatic logic f2_model(input logic [3:0] v);
    return (!v[1] && v[0]) || (v[2] && v[1]) || (v[3] && v[1]);
  endfunction

  assign f1_1 = tie0 ? 1'b0 : (f1_model({a1, b1, c1, d1}) ^ flip1[{a1, b1, c1, d1}]);
  assign f2_1 = f2_model({w1, x1, y1, z1}) ^ flip2[{w1, x1, y1, z1}];
  assign f1_3 = f1_model({a3, b3, c3, d3});
  assign f2_3 = f2_model({w3, x3, y3, z3});

  boolean_min_sweeper #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f1(f1_1), .f2(f2_1),
    .a(a1), .b(b1), .c(c1), .d(d1), .w(w1), .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_idx(fidx1), .first_err_valid(fv1)
`ifdef BOOLEAN_MIN_SWEEPER_ERR_MASK_EN
    , .f1_err_mask(m1_1), .f2_err_mask(m2_1)
`endif
  );

  boolean_min_sweeper #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f1(f1_3), .f2(f2_3),
    .a(a3), .b(b3), .c(c3), .d(d3), .w(w3), .x(x3), .y(y3), .z(z3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .first_err_idx(fidx3), .first_err_valid(fv3)
`ifdef BOOLEAN_MIN_SWEEPER_ERR_MASK_EN
    , .f1_err_mask(m1_3), .f2_err_mask(m2_3)
`endif
  );

`ifndef BOOLEAN_MIN_SWEEPER_ERR_MASK_EN
  assign m1_1 = 16'd0;
  assign m2_1 = 16'd0;
  assign m1_3 = 16'd0;
  assign m2_3 = 16'd0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected results: observed function vs golden table, vector by vector
  task automatic expect_of(input bit t0, input logic [15:0] fl1, input logic [15:0] fl2,
                           output int ne, output int fi,
                           output logic [15:0] em1, output logic [15:0] em2);
    logic [3:0] v;
    logic o1, o2;
    ne = 0; fi = 0; em1 = 16'd0; em2 = 16'd0;
    for (int i = 0; i < 16; i++) begin
      v  = 4'(i);
      o1 = t0 ? 1'b0 : (f1_model(v) ^ fl1[i]);
      o2 = f2_model(v) ^ fl2[i];
      em1[i] = (o1 != g1[i]);
      em2[i] = (o2 != g2[i]);
      if (em1[i] || em2[i]) begin
        if (ne == 0) fi = i;
        ne++;
      end
    end
  endtask

  task automatic sweep1(input int restart_at, input int rst_at);
    int k;
    bit stim_bad, busy_bad, overlap, aborted;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("clear_err_on_start", err1, 0);
    chk("clear_fv_on_start", fv1, 0);
    chk("done_low_after_start", done1, 0);
    k = 0; stim_bad = 0; busy_bad = 0; overlap = 0; aborted = 0;
    while (!done1 && k < 200) begin
      if ({a1, b1, c1, d1} != 4'(k / 2) || {w1, x1, y1, z1} != 4'(k / 2)) stim_bad = 1;
      if (!busy1) busy_bad = 1;
      start1 = (k == restart_at);
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy1, 0);
        chk("rst_mid_done", done1, 0);
        chk("rst_mid_err", err1, 0);
        chk("rst_mid_fv", fv1, 0);
        chk("rst_mid_fidx", fidx1, 0);
        chk("rst_mid_pass", pass1, 0);
        chk("rst_mid_stim", {a1, b1, c1, d1, w1, x1, y1, z1}, 0);
        chk("rst_mid_mask", {m1_1, m2_1}, 0);
        aborted = 1;
        break;
      end
      @(negedge clk);
      k++;
      if (busy1 && done1) overlap = 1;
    end
    start1 = 1'b0;
    if (!aborted) begin
      chk("sweep_len", k, 32);
      chk("stim_sequence", stim_bad, 0);
      chk("busy_during_sweep", busy_bad, 0);
      chk("busy_done_overlap", overlap, 0);
      chk("stim_hold_in_done", {a1, b1, c1, d1}, 15);
    end
  endtask

  typedef struct {
    bit          t0;
    logic [15:0] fl1, fl2;
    int          err, first;
    bit          fv, ps;
    logic [15:0] em1, em2;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ne, fi, k;
    logic [15:0] em1, em2;
    bit stim_bad;
    int f1_min[8]  = '{0, 2, 5, 7, 8, 10, 12, 13};
    int f2_min[10] = '{1, 5, 6, 7, 9, 10, 11, 13, 14, 15};

    g1 = 16'd0; g2 = 16'd0;
    foreach (f1_min[i]) g1[f1_min[i]] = 1'b1;
    foreach (f2_min[i]) g2[f2_min[i]] = 1'b1;

    tbl[0] = '{1'b0, 16'h0000, 16'h0000,  0,  0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 16'h0000, 16'h0000,  8,  0, 1'b1, 1'b0, 16'h35A5, 16'h0000};
    tbl[2] = '{1'b0, 16'h0000, 16'h0200,  1,  9, 1'b1, 1'b0, 16'h0000, 16'h0200};
    tbl[3] = '{1'b0, 16'h8000, 16'h0000,  1, 15, 1'b1, 1'b0, 16'h8000, 16'h0000};
    tbl[4] = '{1'b0, 16'h0008, 16'h0008,  1,  3, 1'b1, 1'b0, 16'h0008, 16'h0008};
    tbl[5] = '{1'b0, 16'h0001, 16'h0006,  3,  0, 1'b1, 1'b0, 16'h0001, 16'h0006};
    tbl[6] = '{1'b0, 16'hFFFF, 16'hFFFF, 16,  0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF};

    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; tie0 = 1'b0; flip1 = 16'd0; flip2 = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy1, 0);
    chk("reset_done", done1, 0);
    chk("reset_pass", pass1, 0);
    chk("reset_err", err1, 0);
    chk("reset_fidx", fidx1, 0);
    chk("reset_fv", fv1, 0);
    chk("reset_stim", {a1, b1, c1, d1, w1, x1, y1, z1}, 0);
    chk("reset_mask", {m1_1, m2_1}, 0);
    chk("reset_busy3", busy3, 0);
    @(negedge clk);
    chk("idle_no_start", busy1, 0);

    foreach (tbl[i]) begin
      tie0 = tbl[i].t0; flip1 = tbl[i].fl1; flip2 = tbl[i].fl2;
      sweep1(-1, -1);
      chk($sformatf("tbl%0d_err_cnt", i), err1, tbl[i].err);
      chk($sformatf("tbl%0d_first_idx", i), fidx1, tbl[i].first);
      chk($sformatf("tbl%0d_first_valid", i), fv1, tbl[i].fv);
      chk($sformatf("tbl%0d_pass", i), pass1, tbl[i].ps);
`ifdef BOOLEAN_MIN_SWEEPER_ERR_MASK_EN
      chk($sformatf("tbl%0d_f1_mask", i), m1_1, tbl[i].em1);
      chk($sformatf("tbl%0d_f2_mask", i), m2_1, tbl[i].em2);
`endif
    end

    repeat (3) @(negedge clk);
    chk("done_hold", done1, 1);
    chk("done_hold_err", err1, 16);

    for (int r = 0; r < 6; r++) begin
      tie0  = 1'b0;
      flip1 = 16'($urandom) & 16'($urandom) & 16'($urandom);
      flip2 = 16'($urandom) & 16'($urandom) & 16'($urandom);
      expect_of(1'b0, flip1, flip2, ne, fi, em1, em2);
      sweep1(-1, -1);
      chk($sformatf("rnd%0d_err_cnt", r), err1, ne);
      chk($sformatf("rnd%0d_first_valid", r), fv1, (ne != 0) ? 1 : 0);
      chk($sformatf("rnd%0d_first_idx", r), fidx1, fi);
      chk($sformatf("rnd%0d_pass", r), pass1, (ne == 0) ? 1 : 0);
`ifdef BOOLEAN_MIN_SWEEPER_ERR_MASK_EN
      chk($sformatf("rnd%0d_f1_mask", r), m1_1, em1);
      chk($sformatf("rnd%0d_f2_mask", r), m2_1, em2);
`endif
    end

    // start during busy is ignored
    tie0 = 1'b1; flip1 = 16'd0; flip2 = 16'd0;
    sweep1(10, -1);
    chk("restart_ignored_err", err1, 8);
    chk("restart_ignored_pass", pass1, 0);
    tie0 = 1'b0;
    sweep1(-1, -1);
    chk("rerun_clears_err", err1, 0);
    chk("rerun_pass", pass1, 1);

    // reset mid-sweep, then a clean sweep
    tie0 = 1'b1;
    sweep1(-1, 15);
    @(negedge clk);
    chk("idle_after_rst", busy1, 0);
    tie0 = 1'b0;
    sweep1(-1, -1);
    chk("post_rst_err", err1, 0);
    chk("post_rst_pass", pass1, 1);
    chk("post_rst_fv", fv1, 0);

    // start and rst together: rst wins
    start1 = 1'b1; rst = 1'b1;
    @(negedge clk);
    start1 = 1'b0; rst = 1'b0;
    chk("start_rst_busy", busy1, 0);
    chk("start_rst_done", done1, 0);
    chk("start_rst_pass", pass1, 0);
    @(negedge clk);
    chk("start_rst_no_late_start", busy1, 0);

    // SETTLE=3 instance
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    k = 0; stim_bad = 0;
    while (!done3 && k < 300) begin
      if ({a3, b3, c3, d3} != 4'(k / 4) || {w3, x3, y3, z3} != 4'(k / 4) || !busy3) stim_bad = 1;
      @(negedge clk);
      k++;
    end
    chk("settle3_len", k, 64);
    chk("settle3_stim", stim_bad, 0);
    chk("settle3_err", err3, 0);
    chk("settle3_pass", pass3, 1);
    chk("settle3_fv", fv3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
